// File: rtl/soft_start_ramp.sv
// soft_start_ramp: ramps the dpwm on-time command to its target one step per STEP_PERIODS switching periods
module soft_start_ramp #(
  parameter int TON_W        = 11,
  parameter int STEP         = 1,
  parameter int STEP_PERIODS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [TON_W-1:0] i_ton_target,
  input  logic             i_ts_last,
  output logic [TON_W-1:0] o_ton,
  output logic             o_pwm_en,
  output logic             o_done
);
  typedef enum logic [1:0] {IDLE, RAMP, RUN} state_t;
  localparam logic [7:0]     P_LAST = 8'(STEP_PERIODS - 1);
  localparam logic [TON_W:0] STEP_W = (TON_W + 1)'(STEP);
  state_t           state, state_nx;
  logic [7:0]       pcnt, pcnt_nx;
  logic [TON_W-1:0] tgt, tgt_nx, ton_nx, stepped;
  logic             en_nx, done_nx;
  logic [TON_W:0]   sum;
  // one extra bit so the increment cannot wrap before the clamp
  assign sum     = {1'b0, o_ton} + STEP_W;
  assign stepped = sum > {1'b0, i_ton_target} ? i_ton_target : sum[TON_W-1:0];
  always_comb begin
    state_nx = state;
    pcnt_nx  = pcnt;
    tgt_nx   = tgt;
    ton_nx   = o_ton;
    en_nx    = o_pwm_en;
    done_nx  = o_done;
    if (!enable) begin
      state_nx = IDLE;
      pcnt_nx  = '0;
      ton_nx   = '0;
      en_nx    = 1'b0;
      done_nx  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = RAMP;
          tgt_nx   = i_ton_target;
          en_nx    = 1'b1;
          pcnt_nx  = '0;
          ton_nx   = '0;
          done_nx  = 1'b0;
        end
        RAMP: if (i_ts_last) begin
          if (pcnt == P_LAST) begin
            pcnt_nx = '0;
            tgt_nx  = i_ton_target;
            ton_nx  = stepped;
            if (stepped == i_ton_target) begin
              state_nx = RUN;
              done_nx  = 1'b1;
            end
          end else begin
            pcnt_nx = pcnt + 8'd1;
          end
        end
        RUN: if (i_ts_last) begin
          tgt_nx = i_ton_target;
          if (i_ton_target <= o_ton) begin
            ton_nx = i_ton_target;
          end else begin
            state_nx = RAMP;
            pcnt_nx  = '0;
            done_nx  = 1'b0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pcnt     <= '0;
      tgt      <= '0;
      o_ton    <= '0;
      o_pwm_en <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      state    <= state_nx;
      pcnt     <= pcnt_nx;
      tgt      <= tgt_nx;
      o_ton    <= ton_nx;
      o_pwm_en <= en_nx;
      o_done   <= done_nx;
    end
  end
endmodule

// File: tb/tb_soft_start_ramp.sv
// tb_soft_start_ramp: directed vector table plus hand sequences for ramp, step-down, disable, async reset and STEP=3 clamp
module tb_soft_start_ramp;
  logic        clk, rst_n, en, ts, en3;
  logic [10:0] tgt, tgt3, ton, ton3;
  logic        pwm, done, pwm3, done3;
  logic [10:0] exp_ton;
  logic        exp_en, exp_done;
  int          checks, errors;
  typedef struct {
    logic        en;
    logic [10:0] tgt;
    logic        ts;
    logic [10:0] ton;
    logic        pwm;
    logic        done;
  } vec_t;
  vec_t vecs[7];
  soft_start_ramp dut (
    .clk(clk), .rst_n(rst_n), .enable(en), .i_ton_target(tgt), .i_ts_last(ts),
    .o_ton(ton), .o_pwm_en(pwm), .o_done(done)
  );
  soft_start_ramp #(.TON_W(11), .STEP(3), .STEP_PERIODS(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .enable(en3), .i_ton_target(tgt3), .i_ts_last(ts),
    .o_ton(ton3), .o_pwm_en(pwm3), .o_done(done3)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [10:0] a_ton, input logic a_en, input logic a_done,
                     input logic [10:0] e_ton, input logic e_en, input logic e_done);
    checks++;
    if (a_ton !== e_ton || a_en !== e_en || a_done !== e_done) begin
      errors++;
      $display("FAIL %s: got ton=%0d pwm_en=%0b done=%0b, want ton=%0d pwm_en=%0b done=%0b",
               nm, a_ton, a_en, a_done, e_ton, e_en, e_done);
    end
  endtask
  task automatic tick(input logic ts_v);
    ts = ts_v;
    @(posedge clk);
    #1;
    ts = 1'b0;
  endtask
  task automatic expect_now(input string nm, input logic [10:0] e_ton, input logic e_en, input logic e_done);
    exp_ton  = e_ton;
    exp_en   = e_en;
    exp_done = e_done;
    chk(nm, ton, pwm, done, exp_ton, exp_en, exp_done);
  endtask
  // 19 quiet clocks (outputs must hold), then a strobe edge carrying the new inputs
  task automatic strobe(input string nm, input logic en_v, input logic [10:0] tgt_v,
                        input logic [10:0] e_ton, input logic e_en, input logic e_done);
    repeat (19) tick(1'b0);
    chk({nm, "_hold"}, ton, pwm, done, exp_ton, exp_en, exp_done);
    en  = en_v;
    tgt = tgt_v;
    tick(1'b1);
    expect_now(nm, e_ton, e_en, e_done);
  endtask
  task automatic ramp_to(input string nm, input logic [10:0] t, input int from, input int to);
    for (int k = from; k <= to; k++) begin
      for (int j = 0; j < 3; j++) strobe({nm, "_wait"}, 1'b1, t, 11'(k - 1), 1'b1, 1'b0);
      strobe({nm, "_step"}, 1'b1, t, 11'(k), 1'b1, 11'(k) == t);
    end
  endtask
  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    en = 1'b0; tgt = '0; ts = 1'b0;
    en3 = 1'b0; tgt3 = '0;
    vecs[0] = '{1'b0, 11'd10, 1'b1, 11'd0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 11'd10, 1'b1, 11'd0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 11'd10, 1'b0, 11'd0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 11'd10, 1'b1, 11'd0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 11'd10, 1'b1, 11'd0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 11'd10, 1'b1, 11'd0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 11'd10, 1'b1, 11'd1, 1'b1, 1'b0};
    #12;
    expect_now("reset", 11'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].ts) begin
        strobe($sformatf("vec%0d", i), vecs[i].en, vecs[i].tgt, vecs[i].ton, vecs[i].pwm, vecs[i].done);
      end else begin
        en  = vecs[i].en;
        tgt = vecs[i].tgt;
        tick(1'b0);
        expect_now($sformatf("vec%0d", i), vecs[i].ton, vecs[i].pwm, vecs[i].done);
      end
    end
    ramp_to("ramp10", 11'd10, 2, 10);
    strobe("run_down", 1'b1, 11'd4, 11'd4, 1'b1, 1'b1);
    strobe("run_up", 1'b1, 11'd8, 11'd4, 1'b1, 1'b0);
    ramp_to("ramp8", 11'd8, 5, 8);
    en = 1'b0;
    tick(1'b0);
    expect_now("disable_run", 11'd0, 1'b0, 1'b0);
    en = 1'b1;
    tgt = 11'd10;
    tick(1'b0);
    expect_now("reenable", 11'd0, 1'b1, 1'b0);
    ramp_to("ramp5", 11'd10, 1, 5);
    strobe("pcnt1", 1'b1, 11'd10, 11'd5, 1'b1, 1'b0);
    strobe("pcnt2", 1'b1, 11'd10, 11'd5, 1'b1, 1'b0);
    en = 1'b0;
    tick(1'b0);
    expect_now("drop_mid", 11'd0, 1'b0, 1'b0);
    en = 1'b1;
    tick(1'b0);
    expect_now("restart", 11'd0, 1'b1, 1'b0);
    ramp_to("fresh_pcnt", 11'd10, 1, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", ton, pwm, done, 11'd0, 1'b0, 1'b0);
    en = 1'b0;
    #3 rst_n = 1'b1;
    tick(1'b0);
    expect_now("post_rst", 11'd0, 1'b0, 1'b0);
    en = 1'b1;
    tgt = 11'd0;
    tick(1'b0);
    expect_now("t0_enable", 11'd0, 1'b1, 1'b0);
    for (int j = 0; j < 3; j++) strobe("t0_wait", 1'b1, 11'd0, 11'd0, 1'b1, 1'b0);
    strobe("t0_done", 1'b1, 11'd0, 11'd0, 1'b1, 1'b1);
    en = 1'b0;
    tick(1'b0);
    expect_now("t0_disable", 11'd0, 1'b0, 1'b0);
    strobe("off_strobe1", 1'b0, 11'd9, 11'd0, 1'b0, 1'b0);
    strobe("off_strobe2", 1'b0, 11'd9, 11'd0, 1'b0, 1'b0);
    chk("step3_idle", ton3, pwm3, done3, 11'd0, 1'b0, 1'b0);
    en3 = 1'b1;
    tgt3 = 11'd7;
    for (int s = 1; s <= 12; s++) begin
      strobe("step3_main_off", 1'b0, 11'd9, 11'd0, 1'b0, 1'b0);
      chk($sformatf("step3_s%0d", s), ton3, pwm3, done3,
          (s / 4 * 3 > 7) ? 11'd7 : 11'(s / 4 * 3), 1'b1, s >= 12);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
